// File: rtl/bitblaster_pkg.sv
// Shared definitions for the bitblaster control path: opcodes, timesteps
// and the instruction word layout held in the instruction register.
package bitblaster_pkg;

  localparam int unsigned INSTR_W  = 10;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned RFLD_W   = 2;
  localparam int unsigned TSTEP_W  = 2;
  localparam int unsigned OPC_LSB  = 6;
  localparam int unsigned RX_LSB   = 4;
  localparam int unsigned RY_LSB   = 2;
  localparam int unsigned NREG_DEF = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_LD  = 4'b0000,
    OP_MOV = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110,
    OP_NOT = 4'b0111
  } opcode_t;

  typedef enum logic [TSTEP_W-1:0] {
    TS_T0 = 2'd0,
    TS_T1 = 2'd1,
    TS_T2 = 2'd2,
    TS_T3 = 2'd3
  } tstep_t;

  // Instruction word as held in the IR; the low field is reserved.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [RFLD_W-1:0] rx;
    logic [RFLD_W-1:0] ry;
    logic [RFLD_W-1:0] rsvd;
  } instr_t;

  // ALU ops (ADD..NOT) run the full four-step sequence.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
    return (opc >= OPC_W'(OP_ADD)) && (opc <= OPC_W'(OP_NOT));
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control bundle between the instruction register/datapath and the sequencer.
interface instr_sequencer_if #(
  parameter int unsigned NREG = bitblaster_pkg::NREG_DEF
);
  import bitblaster_pkg::*;

  logic                 Exec;
  logic [INSTR_W-1:0]   INSTR;
  logic                 IR_EN;
  logic [TSTEP_W-1:0]   T;
  logic [NREG-1:0]      Rin;
  logic [NREG-1:0]      Rout;
  logic                 Ain;
  logic                 Gin;
  logic                 Gout;
  logic                 ExtOut;
  logic [OPC_W-1:0]     ALUcont;
  logic                 Done;

  modport master (
    input  Exec, INSTR,
    output IR_EN, T, Rin, Rout, Ain, Gin, Gout, ExtOut, ALUcont, Done
  );

  modport slave (
    output Exec, INSTR,
    input  IR_EN, T, Rin, Rout, Ain, Gin, Gout, ExtOut, ALUcont, Done
  );

endinterface

// File: rtl/dec2to4.sv
// Combinational 2-to-4 one-hot decoder with enable.
module dec2to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Timestep sequencer: fetches an instruction in T0, then drives one-hot
// register-file, accumulator, ALU and bus controls through T1..T3.
module instr_sequencer
  import bitblaster_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF
) (
  input  logic               CLKb,
  input  logic               RSTb,
  instr_sequencer_if.master  bus
);

  localparam logic [TSTEP_W-1:0] S_T0 = TS_T0;
  localparam logic [TSTEP_W-1:0] S_T1 = TS_T1;
  localparam logic [TSTEP_W-1:0] S_T2 = TS_T2;
  localparam logic [TSTEP_W-1:0] S_T3 = TS_T3;

  logic [TSTEP_W-1:0] state;
  logic [TSTEP_W-1:0] state_nx;

  logic [OPC_W-1:0]  opc;
  logic [RFLD_W-1:0] rx;
  logic [RFLD_W-1:0] ry;
  logic              alu_op;
  logic              unused_rsvd;

  assign opc         = bus.INSTR[OPC_LSB +: OPC_W];
  assign rx          = bus.INSTR[RX_LSB +: RFLD_W];
  assign ry          = bus.INSTR[RY_LSB +: RFLD_W];
  assign unused_rsvd = ^bus.INSTR[RY_LSB-1:0];
  assign alu_op      = is_alu_op(opc);

  logic             ir_en;
  logic             ain;
  logic             gin;
  logic             gout;
  logic             ext_out;
  logic             done;
  logic [OPC_W-1:0] alu_cont;
  logic             rin_rx;
  logic             rout_rx;
  logic             rout_ry;
  logic [3:0]       rx_oh;
  logic [3:0]       ry_oh;

  // State register, falling-edge clocked to match the IR and datapath.
  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) state <= S_T0;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_T0:    state_nx = bus.Exec ? S_T1 : S_T0;
      S_T1:    state_nx = alu_op ? S_T2 : S_T0;
      S_T2:    state_nx = S_T3;
      S_T3:    state_nx = S_T0;
      default: state_nx = S_T0;
    endcase
  end

  // Control decode; rin_rx/rout_rx/rout_ry select which register field
  // feeds the write or bus-drive one-hot.
  always_comb begin
    ir_en    = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    gout     = 1'b0;
    ext_out  = 1'b0;
    done     = 1'b0;
    alu_cont = '0;
    rin_rx   = 1'b0;
    rout_rx  = 1'b0;
    rout_ry  = 1'b0;
    case (state)
      S_T0: ir_en = bus.Exec & RSTb;
      S_T1: begin
        case (opc)
          OP_LD: begin
            ext_out = 1'b1;
            rin_rx  = 1'b1;
            done    = 1'b1;
          end
          OP_MOV: begin
            rout_ry = 1'b1;
            rin_rx  = 1'b1;
            done    = 1'b1;
          end
          default: begin
            if (alu_op) begin
              rout_rx = 1'b1;
              ain     = 1'b1;
            end else begin
              done    = 1'b1;
            end
          end
        endcase
      end
      S_T2: begin
        if (alu_op) begin
          rout_ry  = (opc != OPC_W'(OP_NOT));
          gin      = 1'b1;
          alu_cont = opc;
        end
      end
      S_T3: begin
        if (alu_op) begin
          gout   = 1'b1;
          rin_rx = 1'b1;
          done   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  dec2to4 u_dec_rx (
    .en  (rin_rx | rout_rx),
    .sel (rx),
    .y   (rx_oh)
  );

  dec2to4 u_dec_ry (
    .en  (rout_ry),
    .sel (ry),
    .y   (ry_oh)
  );

  assign bus.IR_EN   = ir_en;
  assign bus.T       = state;
  assign bus.Rin     = NREG'(rin_rx ? rx_oh : 4'b0000);
  assign bus.Rout    = NREG'((rout_rx ? rx_oh : 4'b0000) | ry_oh);
  assign bus.Ain     = ain;
  assign bus.Gin     = gin;
  assign bus.Gout    = gout;
  assign bus.ExtOut  = ext_out;
  assign bus.ALUcont = alu_cont;
  assign bus.Done    = done;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random instruction
// streams checked against a timestep-table model of the control outputs.
module tb_instr_sequencer;
  import bitblaster_pkg::*;

  logic CLKb;
  logic RSTb;

  instr_sequencer_if #(.NREG(4)) sif ();

  instr_sequencer #(.NREG(4)) dut (
    .CLKb (CLKb),
    .RSTb (RSTb),
    .bus  (sif)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  int         n_tests;
  int         n_fail;
  int         m_step;
  logic [9:0] ir_q;
  logic       ex_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle count of an instruction from fetch to Done.
  function automatic int instr_len(input logic [9:0] ins);
    int opc;
    opc = int'(ins[9:6]);
    return (opc >= 2 && opc <= 7) ? 4 : 2;
  endfunction

  // Expected {IR_EN,T,Rin,Rout,Ain,Gin,Gout,ExtOut,ALUcont,Done}.
  function automatic logic [19:0] model_out(input int step, input logic [9:0] ins,
                                            input logic ex, input logic rst);
    int opc, rx, ry;
    logic ir_en, ain, gin, gout, ext, done;
    logic [3:0] rin, rout, alu;
    opc = int'(ins[9:6]);
    rx  = int'(ins[5:4]);
    ry  = int'(ins[3:2]);
    ir_en = 0; ain = 0; gin = 0; gout = 0; ext = 0; done = 0;
    rin = 0; rout = 0; alu = 0;
    if (step == 0) begin
      ir_en = ex & rst;
    end else if (opc == 0) begin
      ext = 1; rin = 4'(1 << rx); done = 1;
    end else if (opc == 1) begin
      rout = 4'(1 << ry); rin = 4'(1 << rx); done = 1;
    end else if (opc <= 7) begin
      if (step == 1) begin
        rout = 4'(1 << rx); ain = 1;
      end else if (step == 2) begin
        rout = (opc == 7) ? 4'b0000 : 4'(1 << ry);
        gin  = 1;
        alu  = 4'(opc);
      end else begin
        gout = 1; rin = 4'(1 << rx); done = 1;
      end
    end else begin
      done = 1;
    end
    return {ir_en, 2'(step), rin, rout, ain, gin, gout, ext, alu, done};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {sif.IR_EN, sif.T, sif.Rin, sif.Rout, sif.Ain, sif.Gin, sif.Gout,
            sif.ExtOut, sif.ALUcont, sif.Done};
  endfunction

  task automatic compare(input string tag);
    int drivers;
    drivers = $countones(sif.Rout) + int'(sif.Gout) + int'(sif.ExtOut);
    chk(tag, 32'(obs_vec()), 32'(model_out(m_step, ir_q, ex_q, RSTb)));
    chk({tag, "_onedrv"}, 32'(drivers <= 1), 32'd1);
  endtask

  // One clock: drive Exec and the IR input bus, check, then advance the
  // model and emulate the IR capturing the bus on the fetch edge.
  task automatic cyc(input string tag, input logic ex, input logic [9:0] nxt);
    logic load;
    @(posedge CLKb);
    ex_q     = ex;
    sif.Exec = ex;
    #1;
    compare(tag);
    load = (m_step == 0) && ex;
    if (m_step == 0)                         m_step = ex ? 1 : 0;
    else if (m_step == instr_len(ir_q) - 1)  m_step = 0;
    else                                     m_step++;
    @(negedge CLKb);
    #1;
    if (load) begin
      ir_q      = nxt;
      sif.INSTR = ir_q;
    end
  endtask

  task automatic reset_pulse(input string tag);
    @(posedge CLKb);
    #1;
    compare({tag, "_pre"});
    #1;
    RSTb   = 1'b0;
    m_step = 0;
    #1;
    compare({tag, "_async"});
    @(negedge CLKb);
    #1;
    compare({tag, "_hold"});
    sif.Exec = 1'b0;
    ex_q     = 1'b0;
    RSTb     = 1'b1;
  endtask

  initial begin
    instr_t ins;
    n_tests   = 0;
    n_fail    = 0;
    m_step    = 0;
    ex_q      = 1'b0;
    ir_q      = '0;
    RSTb      = 1'b0;
    sif.Exec  = 1'b0;
    sif.INSTR = ir_q;
    #2;
    compare("reset_init");
    #10;
    RSTb = 1'b1;

    reset_pulse("rst_idle");
    repeat (5) cyc("idle", 1'b0, 10'($urandom));

    cyc("ld_r2", 1'b1, 10'b0000_10_00_00);
    cyc("ld_r2", 1'b0, 10'($urandom));
    cyc("ld_r2_back", 1'b0, 10'($urandom));

    ins = '{opcode: OP_ADD, rx: 2'd1, ry: 2'd3, rsvd: 2'd0};
    cyc("add", 1'b1, ins);
    repeat (3) cyc("add", 1'b0, 10'($urandom));
    cyc("add_back", 1'b0, 10'($urandom));

    cyc("not_r0", 1'b1, 10'b0111_00_00_00);
    repeat (3) cyc("not_hold", 1'b1, 10'b0000_01_00_00);
    cyc("not_refetch", 1'b1, 10'b0000_01_00_00);
    cyc("not_next_ld", 1'b0, 10'($urandom));

    cyc("rsv", 1'b1, 10'b1011_01_10_11);
    cyc("rsv", 1'b0, 10'($urandom));
    cyc("mov", 1'b1, 10'b0001_11_00_00);
    cyc("mov", 1'b0, 10'($urandom));
    cyc("mov_back", 1'b0, 10'($urandom));

    ins = '{opcode: OP_SUB, rx: 2'd2, ry: 2'd1, rsvd: 2'd3};
    cyc("sub", 1'b1, ins);
    cyc("sub", 1'b0, 10'($urandom));
    reset_pulse("sub_rst");
    repeat (4) cyc("sub_after", 1'b0, 10'($urandom));

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) reset_pulse("rand_rst");
      cyc("rand", $urandom_range(0, 3) != 0, 10'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
